fp_add_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style binary floating-point adder/subtractor with valid tracking, round-to-nearest-even, special-value handling and status flags.
- Default configuration is binary16, so it drops into the TTPU accumulate path.
- Wider formats (bfloat16, fp32) are reached by changing parameters only.
- One result per enabled cycle; pipeline stalls in place when en is low.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_lzc.sv | 16 +
 rtl/fp_add_pipe.sv | 196 +++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and bit-pattern helpers for the floating-point adder.
package fp_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  // Patterns are built at 64 bits and truncated to DATA_WIDTH by the caller.
  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    logic [63:0] r;
    r = ((64'd1 << ew) - 64'd1) << mw;
    r = r | (64'd1 << (mw - 1));
    return r;
  endfunction

  function automatic logic [63:0] fp_inf(input logic sign, input int ew, input int mw);
    logic [63:0] r;
    r = ((64'd1 << ew) - 64'd1) << mw;
    r = r | ({63'd0, sign} << (ew + mw));
    return r;
  endfunction

  function automatic logic [63:0] fp_max(input logic sign, input int ew, input int mw);
    logic [63:0] r;
    r = (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
    r = r | ({63'd0, sign} << (ew + mw));
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W  = 14,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++)
      if (value[i]) count = CW'(W - 1 - i);
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Four-stage floating-point adder/subtractor (unpack, align, add, normalise/round).
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise truncate and saturate.
module fp_add_pipe import fp_pkg::*; #(
  parameter int EXP_W      = EXP_W_DEF,
  parameter int MAN_W      = MAN_W_DEF,
  parameter int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  out_overflow,
  output logic                  out_invalid
);

  localparam int STAGES = 4;
  localparam int W      = MAN_W + 4;  // hidden, frac, guard, round, sticky
  localparam int CW     = $clog2(W + 1);
  localparam int EW1    = EXP_W + 1;
  localparam int SW     = (CW > EW1) ? CW : EW1;
  localparam logic [EXP_W-1:0] EMAX = '1;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)   return FP_ZERO;
    if (e == EMAX) return (f == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic [STAGES:1] vld_pipe;

  // ---- stage 1: unpack, classify, resolve specials, swap ----
  logic                  sa, sb, swap, spec, spec_inv;
  logic [DATA_WIDTH-2:0] mag_a, mag_b;
  logic [DATA_WIDTH-1:0] spec_res;
  fp_class_t             ca, cb;

  assign sa    = a[DATA_WIDTH-1];
  assign sb    = b[DATA_WIDTH-1] ^ sub;
  assign ca    = classify(a[DATA_WIDTH-2 -: EXP_W], a[MAN_W-1:0]);
  assign cb    = classify(b[DATA_WIDTH-2 -: EXP_W], b[MAN_W-1:0]);
  assign mag_a = (ca == FP_ZERO) ? '0 : a[DATA_WIDTH-2:0];
  assign mag_b = (cb == FP_ZERO) ? '0 : b[DATA_WIDTH-2:0];
  assign swap  = mag_b > mag_a;

  always_comb begin
    spec     = 1'b1;
    spec_inv = 1'b0;
    spec_res = {sa, mag_a};
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF && sa != sb)) begin
      spec_res = DATA_WIDTH'(fp_qnan(EXP_W, MAN_W));
      spec_inv = 1'b1;
    end
    else if (ca == FP_INF)                    spec_res = DATA_WIDTH'(fp_inf(sa, EXP_W, MAN_W));
    else if (cb == FP_INF)                    spec_res = DATA_WIDTH'(fp_inf(sb, EXP_W, MAN_W));
    else if (ca == FP_ZERO && cb == FP_ZERO)  spec_res = {sa & sb, {(DATA_WIDTH-1){1'b0}}};
    else if (ca == FP_ZERO)                   spec_res = {sb, mag_b};
    else if (cb == FP_ZERO)                   spec_res = {sa, mag_a};
    else                                      spec = 1'b0;
  end

  logic                  s1_bs, s1_ss, s1_spec, s1_inv;
  logic [EXP_W-1:0]      s1_be, s1_se;
  logic [MAN_W:0]        s1_bm, s1_sm;
  logic [DATA_WIDTH-1:0] s1_res;

  // ---- stage 2: align small operand against big exponent ----
  logic [EXP_W-1:0] d;
  logic [W-1:0]     ext, mask, aligned;

  assign d    = s1_be - s1_se;
  assign ext  = {s1_sm, 3'b000};
  assign mask = ~({W{1'b1}} << d);
  assign aligned = (32'(d) >= MAN_W + 3) ? W'(1) : ((ext >> d) | W'(|(ext & mask)));

  logic                  s2_sign, s2_esub, s2_spec, s2_inv;
  logic [EXP_W-1:0]      s2_exp;
  logic [W-1:0]          s2_big, s2_small;
  logic [DATA_WIDTH-1:0] s2_res;

  // ---- stage 3: magnitude add/subtract, carry kept ----
  logic [W:0] sum;
  assign sum = s2_esub ? ({1'b0, s2_big} - {1'b0, s2_small}) : ({1'b0, s2_big} + {1'b0, s2_small});

  logic                  s3_sign, s3_spec, s3_inv;
  logic [EXP_W-1:0]      s3_exp;
  logic [W:0]            s3_sum;
  logic [DATA_WIDTH-1:0] s3_res;

  // ---- stage 4: normalise, round, pack ----
  logic [CW-1:0]    lz;
  logic [SW-1:0]    lz_x, e_lim, sh;
  logic [W-1:0]     m;
  logic [EW1-1:0]   e, e2;
  logic [MAN_W-1:0] fr;
  logic             up, rc, unf, ovf;
  logic [DATA_WIDTH-1:0] res_n;
  logic             ovf_n;

  fp_lzc #(.W(W), .CW(CW)) u_lzc (.value(s3_sum[W-1:0]), .count(lz));

  assign lz_x  = SW'(lz);
  assign e_lim = SW'(s3_exp) - SW'(1);
  assign sh    = (lz_x < e_lim) ? lz_x : e_lim;  // never drop exp below 1

  always_comb begin
    if (s3_sum[W]) begin
      m = {s3_sum[W:2], s3_sum[1] | s3_sum[0]};
      e = EW1'(s3_exp) + EW1'(1);
    end else begin
      m = s3_sum[W-1:0] << sh;
      e = EW1'(s3_exp) - EW1'(sh);
    end
  end

`ifdef FPADD_RNE_EN
  assign up = m[2] & (m[1] | m[0] | m[3]);
`else
  assign up = 1'b0;
`endif

  assign {rc, fr} = {1'b0, m[W-2:3]} + (MAN_W+1)'(up);
  assign e2  = e + EW1'(rc);
  assign unf = ~m[W-1];
  assign ovf = e2 >= EW1'(EMAX);

  always_comb begin
    ovf_n = 1'b0;
    if (unf)
      res_n = {s3_sign, {(DATA_WIDTH-1){1'b0}}};
    else if (ovf) begin
      ovf_n = 1'b1;
`ifdef FPADD_RNE_EN
      res_n = DATA_WIDTH'(fp_inf(s3_sign, EXP_W, MAN_W));
`else
      res_n = DATA_WIDTH'(fp_max(s3_sign, EXP_W, MAN_W));
`endif
    end
    else
      res_n = {s3_sign, e2[EXP_W-1:0], fr};
  end

  // Datapath registers need no reset; only valids and outputs are cleared.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_bs   <= swap ? sb : sa;
      s1_ss   <= swap ? sa : sb;
      s1_be   <= swap ? b[DATA_WIDTH-2 -: EXP_W] : a[DATA_WIDTH-2 -: EXP_W];
      s1_se   <= swap ? a[DATA_WIDTH-2 -: EXP_W] : b[DATA_WIDTH-2 -: EXP_W];
      s1_bm   <= {1'b1, swap ? b[MAN_W-1:0] : a[MAN_W-1:0]};
      s1_sm   <= {1'b1, swap ? a[MAN_W-1:0] : b[MAN_W-1:0]};
      s1_spec <= spec;
      s1_inv  <= spec_inv;
      s1_res  <= spec_res;

      s2_sign  <= s1_bs;
      s2_esub  <= s1_bs ^ s1_ss;
      s2_exp   <= s1_be;
      s2_big   <= {s1_bm, 3'b000};
      s2_small <= aligned;
      s2_spec  <= s1_spec;
      s2_inv   <= s1_inv;
      s2_res   <= s1_res;

      s3_sign <= (sum == '0) ? 1'b0 : s2_sign;
      s3_exp  <= s2_exp;
      s3_sum  <= sum;
      s3_spec <= s2_spec;
      s3_inv  <= s2_inv;
      s3_res  <= s2_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe     <= '0;
      result       <= '0;
      out_overflow <= 1'b0;
      out_invalid  <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (vld_pipe[STAGES-1]) begin
        result       <= s3_spec ? s3_res : res_n;
        out_overflow <= s3_spec ? 1'b0 : ovf_n;
        out_invalid  <= s3_spec & s3_inv;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe (binary16); expectations follow FPADD_RNE_EN.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        reset, en, in_valid, sub;
  logic [15:0] a, b;
  logic        out_valid, out_overflow, out_invalid;
  logic [15:0] result;

  fp_add_pipe dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .result(result),
    .out_overflow(out_overflow), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] res;
    logic        ovf, inv;
  } vec_t;

  localparam int NV = 18;
  vec_t vec[NV];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   pv[4:1];
  int   pidx[4:1];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // One clock: drive at negedge, advance the expected-latency model, check #1 after the edge.
  task automatic step(input logic rst, input logic e, input logic iv, input int idx);
    @(negedge clk);
    reset = rst; en = e; in_valid = iv;
    a = vec[idx].a; b = vec[idx].b; sub = vec[idx].sub;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 1; k <= 4; k++) pv[k] = 1'b0;
    end else if (e) begin
      for (int k = 4; k > 1; k--) begin
        pv[k] = pv[k-1]; pidx[k] = pidx[k-1];
      end
      pv[1] = iv; pidx[1] = idx;
    end
    check("out_valid", {15'd0, out_valid}, {15'd0, pv[4]});
    if (pv[4]) begin
      check($sformatf("v%0d result", pidx[4]), result, vec[pidx[4]].res);
      check($sformatf("v%0d overflow", pidx[4]), {15'd0, out_overflow}, {15'd0, vec[pidx[4]].ovf});
      check($sformatf("v%0d invalid", pidx[4]), {15'd0, out_invalid}, {15'd0, vec[pidx[4]].inv});
    end
    if (rst) begin
      check("reset result", result, 16'h0000);
      check("reset flags", {14'd0, out_overflow, out_invalid}, 16'h0000);
    end
  endtask

  initial begin
    vec[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0};
    vec[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0};
    vec[2]  = '{16'h4200, 16'h3C00, 1'b1, 16'h4000, 1'b0, 1'b0};
`ifdef FPADD_RNE_EN
    vec[3]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0};
    vec[4]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0};
    vec[14] = '{16'h3C00, 16'h0400, 1'b1, 16'h3C00, 1'b0, 1'b0};
`else
    vec[3]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C01, 1'b0, 1'b0};
    vec[4]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7BFF, 1'b1, 1'b0};
    vec[14] = '{16'h3C00, 16'h0400, 1'b1, 16'h3BFF, 1'b0, 1'b0};
`endif
    vec[5]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 1'b1};
    vec[6]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b1};
    vec[7]  = '{16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vec[8]  = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0};
    vec[9]  = '{16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1'b0, 1'b0};
    vec[10] = '{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b0, 1'b0};
    vec[11] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0};
    vec[12] = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vec[13] = '{16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 1'b0, 1'b0};
    vec[15] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0};
    vec[16] = '{16'hFC00, 16'hFC00, 1'b0, 16'hFC00, 1'b0, 1'b0};
    vec[17] = '{16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, 1'b0};

    for (int k = 1; k <= 4; k++) begin
      pv[k] = 1'b0; pidx[k] = 0;
    end
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0;

    // reset state, including reset winning over en=0
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 0);

    // isolated ops: out_valid must appear exactly 4 cycles after issue
    for (int i = 0; i < NV; i++) begin
      step(1'b0, 1'b1, 1'b1, i);
      repeat (4) step(1'b0, 1'b1, 1'b0, 0);
    end

    // back-to-back stream with a 3-cycle stall; ignored inputs presented during the stall
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, i);
    repeat (3) step(1'b0, 1'b0, 1'b1, 9);
    step(1'b0, 1'b1, 1'b1, 4);
    step(1'b0, 1'b1, 1'b1, 5);
    step(1'b0, 1'b1, 1'b0, 0);
    // ops 4 and 5 are still in flight here and must never emerge
    step(1'b1, 1'b1, 1'b1, 13);
    step(1'b0, 1'b1, 1'b1, 6);
    step(1'b0, 1'b1, 1'b1, 7);
    step(1'b0, 1'b1, 1'b1, 8);
    step(1'b0, 1'b1, 1'b1, 17);
    repeat (5) step(1'b0, 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
